// File: rtl/iq_gen_hls_deadlock_monitor_param.sv
// Deadlock monitor for an HLS-generated iq_gen instance.
// Qualifies stream/instance stalls with a persistence counter, reports
// per-channel block codes, and keeps sticky first-source and stall-duration
// records for the top-level deadlock report.
module iq_gen_hls_deadlock_monitor_param #(
  parameter int NUM_AXIS = 4,
  parameter int NUM_INST = 1,
  parameter int FIELD_W  = 4,
  parameter int THRESH_W = 8,
  parameter int IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [THRESH_W-1:0]         threshold,
  input  logic [NUM_AXIS-1:0]         axis_block_sigs,
  input  logic [NUM_INST-1:0]         inst_idle_sigs,
  input  logic [NUM_INST-1:0]         inst_block_sigs,
  output logic [NUM_AXIS*FIELD_W-1:0] axis_block_info,
  output logic                        block,
  output logic                        block_sticky,
  output logic                        first_valid,
  output logic                        first_is_inst,
  output logic [IDX_W-1:0]            first_axis,
  output logic [15:0]                 block_cycles
);

  logic                        inst_stall;
  logic                        raw;
  logic                        blk_nxt;
  logic [IDX_W-1:0]            low_idx;

  logic [THRESH_W-1:0]         cnt_q, cnt_d;
  logic                        block_q, block_d;
  logic [NUM_AXIS*FIELD_W-1:0] info_q, info_d;
  logic                        sticky_q, sticky_d;
  logic                        fv_q, fv_d;
  logic                        fi_q, fi_d;
  logic [IDX_W-1:0]            fa_q, fa_d;
  logic [15:0]                 cycles_q, cycles_d;

  // Raw stall detection: any stream blocked, or every instance parked with at least one blocked.
  always_comb begin
    inst_stall = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
    raw        = (|axis_block_sigs) | inst_stall;
    blk_nxt    = raw & (cnt_q >= threshold);
  end

  // Lowest blocked channel index, 0 when no channel is blocked.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) low_idx = IDX_W'(i);
    end
  end

  // Persistence counter, qualified block and per-channel info codes.
  always_comb begin
    cnt_d   = '0;
    if (raw) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    block_d = blk_nxt;
    info_d  = '0;
    for (int i = 0; i < NUM_AXIS; i++) begin
      if (axis_block_sigs[i])
        info_d[i*FIELD_W +: FIELD_W] = ~(FIELD_W'(1) << (i % FIELD_W));
    end
  end

  // Sticky, first-source capture and stall statistics; clear has priority.
  always_comb begin
    sticky_d = sticky_q;
    fv_d     = fv_q;
    fi_d     = fi_q;
    fa_d     = fa_q;
    cycles_d = cycles_q;
    if (block_q && (cycles_q != 16'hFFFF)) cycles_d = cycles_q + 16'd1;
    if (clear) begin
      sticky_d = 1'b0;
      fv_d     = 1'b0;
      fi_d     = 1'b0;
      fa_d     = '0;
      cycles_d = '0;
    end else if (blk_nxt) begin
      sticky_d = 1'b1;
      if (!fv_q) begin
        fv_d = 1'b1;
        fi_d = (axis_block_sigs == '0);
        fa_d = low_idx;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      block_q  <= 1'b0;
      info_q   <= '0;
      sticky_q <= 1'b0;
      fv_q     <= 1'b0;
      fi_q     <= 1'b0;
      fa_q     <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      info_q   <= info_d;
      sticky_q <= sticky_d;
      fv_q     <= fv_d;
      fi_q     <= fi_d;
      fa_q     <= fa_d;
      cycles_q <= cycles_d;
    end
  end

  // Info fields are only visible while the qualified block is asserted.
  always_comb begin
    axis_block_info = block_q ? info_q : '0;
    block           = block_q;
    block_sticky    = sticky_q;
    first_valid     = fv_q;
    first_is_inst   = fi_q;
    first_axis      = fa_q;
    block_cycles    = cycles_q;
  end

endmodule
